operand_entry_ctrl: RTL and testbench

Front-end sequencer for the register-ALU display stage. It conditions two raw push-buttons (enter, cancel) and walks the operator through entering operand A, operand B and the opcode from the shared switch bus. It emits the single-cycle load_A / load_B / load_Op / update_Res strobes that the register-ALU display stage consumes. It sits directly upstream of that stage; data_in goes to it straight from the switches and does not pass through this block.

---
 rtl/operand_entry_ctrl.sv | 152 +++++++++++++++
 tb/tb_operand_entry_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_entry_ctrl.sv
// Operand entry sequencer: conditions the enter/cancel buttons and steps the
// operator through A, B and opcode entry, emitting registered load strobes.
module operand_entry_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_enter,
  input  logic       btn_cancel,
  output logic       load_A,
  output logic       load_B,
  output logic       load_Op,
  output logic       update_Res,
  output logic [3:0] step_leds
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_A   = 3'd0,
    S_B   = 3'd1,
    S_OP  = 3'd2,
    S_UPD = 3'd3,
    S_RES = 3'd4
  } state_t;

  logic [1:0] btn_raw;
  logic [1:0] press_ev;
  logic       enter_ev;
  logic       cancel_ev;

  assign btn_raw   = {btn_cancel, btn_enter};
  assign enter_ev  = press_ev[0];
  assign cancel_ev = press_ev[1];

  // Bit 0 conditions enter, bit 1 conditions cancel.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : gen_btn
      logic             sync1_q, sync1_d;
      logic             sync2_q, sync2_d;
      logic             db_q, db_d;
      logic             db_prev_q, db_prev_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;

      always_comb begin
        sync1_d   = btn_raw[gi];
        sync2_d   = sync1_q;
        db_prev_d = db_q;
        db_d      = db_q;
        cnt_d     = '0;
        // A disagreement must persist DEBOUNCE_CYCLES cycles; any agreement restarts it.
        if (sync2_q != db_q) begin
          if (cnt_q == CNT_MAX) begin
            db_d  = sync2_q;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          sync1_q   <= 1'b0;
          sync2_q   <= 1'b0;
          db_q      <= 1'b0;
          db_prev_q <= 1'b0;
          cnt_q     <= '0;
        end else begin
          sync1_q   <= sync1_d;
          sync2_q   <= sync2_d;
          db_q      <= db_d;
          db_prev_q <= db_prev_d;
          cnt_q     <= cnt_d;
        end
      end

      assign press_ev[gi] = db_q & ~db_prev_q;
    end
  endgenerate

  state_t state_q, state_d;
  logic   load_a_q, load_a_d;
  logic   load_b_q, load_b_d;
  logic   load_op_q, load_op_d;
  logic   update_res_q, update_res_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_A;
      load_a_q     <= 1'b0;
      load_b_q     <= 1'b0;
      load_op_q    <= 1'b0;
      update_res_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      load_a_q     <= load_a_d;
      load_b_q     <= load_b_d;
      load_op_q    <= load_op_d;
      update_res_q <= update_res_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_A:   if (cancel_ev) state_d = S_A;  else if (enter_ev) state_d = S_B;
      S_B:   if (cancel_ev) state_d = S_A;  else if (enter_ev) state_d = S_OP;
      S_OP:  if (cancel_ev) state_d = S_A;  else if (enter_ev) state_d = S_UPD;
      S_UPD: state_d = S_RES;
      S_RES: if (cancel_ev || enter_ev) state_d = S_A;
      default: state_d = S_A;
    endcase
  end

  // Cancel masks enter, so a simultaneous press never raises a strobe.
  always_comb begin
    load_a_d     = 1'b0;
    load_b_d     = 1'b0;
    load_op_d    = 1'b0;
    update_res_d = 1'b0;
    step_leds    = 4'b0001;
    case (state_q)
      S_A: begin
        load_a_d  = enter_ev & ~cancel_ev;
        step_leds = 4'b0001;
      end
      S_B: begin
        load_b_d  = enter_ev & ~cancel_ev;
        step_leds = 4'b0010;
      end
      S_OP: begin
        load_op_d = enter_ev & ~cancel_ev;
        step_leds = 4'b0100;
      end
      S_UPD: begin
        update_res_d = 1'b1;
        step_leds    = 4'b1000;
      end
      S_RES: step_leds = 4'b1000;
      default: step_leds = 4'b0001;
    endcase
  end

  assign load_A     = load_a_q;
  assign load_B     = load_b_q;
  assign load_Op    = load_op_q;
  assign update_Res = update_res_q;

endmodule

// File: tb/tb_operand_entry_ctrl.sv
// Bench for operand_entry_ctrl: scenario tasks plus a cycle-level model built
// from sample-window acceptance of the button levels and an operator step count.
module tb_operand_entry_ctrl;

  localparam int DC = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_enter = 1'b0;
  logic       btn_cancel = 1'b0;
  logic       load_A, load_B, load_Op, update_Res;
  logic [3:0] step_leds;

  int checks = 0;
  int passes = 0;

  operand_entry_ctrl #(.DEBOUNCE_CYCLES(DC)) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_enter  (btn_enter),
    .btn_cancel (btn_cancel),
    .load_A     (load_A),
    .load_B     (load_B),
    .load_Op    (load_Op),
    .update_Res (update_Res),
    .step_leds  (step_leds)
  );

  always #5 clk = ~clk;

  // Reference model. A level is accepted once the samples taken DC+1..2 edges
  // ago all disagree with the accepted level; a 0->1 acceptance acts next edge.
  // Operator step: 0=A 1=B 2=OP 3=update 4=RES.
  bit qe[$];
  bit qc[$];
  bit mdb_e, mdb_c, pend_e, pend_c;
  int m_step;
  logic m_la, m_lb, m_lo, m_up;

  function automatic logic [3:0] leds_of(input int s);
    if (s >= 3) return 4'b1000;
    return 4'(1 << s);
  endfunction

  function automatic bit accept(input bit q[$], input bit level);
    for (int i = 0; i < DC; i++)
      if (q[i] == level) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      qe.delete();
      qc.delete();
      for (int i = 0; i < DC + 2; i++) begin
        qe.push_back(1'b0);
        qc.push_back(1'b0);
      end
      mdb_e = 1'b0; mdb_c = 1'b0; pend_e = 1'b0; pend_c = 1'b0;
      m_step = 0;
      m_la = 1'b0; m_lb = 1'b0; m_lo = 1'b0; m_up = 1'b0;
    end else begin
      m_la = 1'b0; m_lb = 1'b0; m_lo = 1'b0; m_up = 1'b0;
      if (m_step == 3) begin
        m_up = 1'b1;
        m_step = 4;
      end else if (pend_c) begin
        m_step = 0;
      end else if (pend_e) begin
        if (m_step == 0) m_la = 1'b1;
        if (m_step == 1) m_lb = 1'b1;
        if (m_step == 2) m_lo = 1'b1;
        m_step = (m_step == 4) ? 0 : m_step + 1;
      end
      qe.push_back(btn_enter);  void'(qe.pop_front());
      qc.push_back(btn_cancel); void'(qc.pop_front());
      pend_e = 1'b0;
      pend_c = 1'b0;
      if (accept(qe, mdb_e)) begin pend_e = !mdb_e; mdb_e = !mdb_e; end
      if (accept(qc, mdb_c)) begin pend_c = !mdb_c; mdb_c = !mdb_c; end
    end
  end

  logic [7:0] exp_vec;
  assign exp_vec = {m_la, m_lb, m_lo, m_up, leds_of(m_step)};

  // Per-cycle observation bookkeeping (no pass/fail decisions here).
  int cyc = 0;
  int mm, mm_first;
  int n_la, n_lb, n_lo, n_up;
  int f_la, f_lo, f_up;

  task automatic clear_obs();
    mm = 0; mm_first = -1;
    n_la = 0; n_lb = 0; n_lo = 0; n_up = 0;
    f_la = -1; f_lo = -1; f_up = -1;
  endtask

  task automatic step(input logic e, input logic c);
    btn_enter = e;
    btn_cancel = c;
    @(posedge clk);
    #1;
    cyc++;
    if ({load_A, load_B, load_Op, update_Res, step_leds} !== exp_vec ||
        (int'(load_A) + int'(load_B) + int'(load_Op) + int'(update_Res)) > 1) begin
      mm++;
      if (mm_first < 0) mm_first = cyc;
    end
    if (load_A)     begin n_la++; if (f_la < 0) f_la = cyc; end
    if (load_B)     n_lb++;
    if (load_Op)    begin n_lo++; if (f_lo < 0) f_lo = cyc; end
    if (update_Res) begin n_up++; if (f_up < 0) f_up = cyc; end
  endtask

  task automatic press(input logic e, input logic c, input int hi, input int lo);
    repeat (hi) step(e, c);
    repeat (lo) step(1'b0, 1'b0);
  endtask

  task automatic test_reset();
    bit found;
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({load_A, load_B, load_Op, update_Res, step_leds} !== 8'b0000_0001)
      $display("FAIL reset_initial got=%b want=00000001", {load_A, load_B, load_Op, update_Res, step_leds});
    else passes++;
    reset = 1'b1;
    clear_obs();
    press(1'b1, 1'b0, 8, 8);
    press(1'b1, 1'b0, 8, 8);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      step(1'b1, 1'b0);
      if (m_lo) found = 1'b1;
    end
    checks++;
    if (!found || mm != 0)
      $display("FAIL reset_presequence reached_op=%0d model_mismatch_cycles=%0d first=%0d want 1/0", found, mm, mm_first);
    else passes++;
    // Assert reset while load_Op is in flight and the FSM sits in the update step.
    reset = 1'b0;
    #1;
    checks++;
    if ({load_A, load_B, load_Op, update_Res, step_leds} !== 8'b0000_0001)
      $display("FAIL reset_async got=%b want=00000001", {load_A, load_B, load_Op, update_Res, step_leds});
    else passes++;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    reset = 1'b1;
    clear_obs();
    repeat (50) step(1'b0, 1'b0);
    checks++;
    if (n_la + n_lb + n_lo + n_up != 0 || mm != 0)
      $display("FAIL reset_idle strobes=%0d mismatches=%0d want 0/0", n_la + n_lb + n_lo + n_up, mm);
    else passes++;
    checks++;
    if (step_leds !== 4'b0001) $display("FAIL reset_idle_leds got=%b want=0001", step_leds);
    else passes++;
  endtask

  task automatic test_full_sequence();
    logic [3:0] want [4];
    int start;
    want = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    clear_obs();
    start = cyc;
    for (int p = 0; p < 4; p++) begin
      press(1'b1, 1'b0, 10, 10);
      checks++;
      if (step_leds !== want[p]) $display("FAIL full_leds_%0d got=%b want=%b", p, step_leds, want[p]);
      else passes++;
    end
    checks++;
    if (n_la != 1 || n_lb != 1 || n_lo != 1 || n_up != 1)
      $display("FAIL full_counts got=%0d%0d%0d%0d want=1111", n_la, n_lb, n_lo, n_up);
    else passes++;
    checks++;
    if (f_up != f_lo + 1) $display("FAIL full_upd_follow got=%0d want=%0d", f_up, f_lo + 1);
    else passes++;
    checks++;
    if (f_la - start != DC + 3) $display("FAIL full_latency got=%0d want=%0d", f_la - start, DC + 3);
    else passes++;
    checks++;
    if (mm != 0) $display("FAIL full_model mismatches=%0d first=%0d want 0", mm, mm_first);
    else passes++;
  endtask

  task automatic test_bounce();
    int start;
    clear_obs();
    for (int i = 0; i < 20; i++) step(((i / 2) % 2) == 0, 1'b0);
    start = cyc;
    repeat (15) step(1'b1, 1'b0);
    for (int i = 0; i < 20; i++) step(((i / 2) % 2) == 1, 1'b0);
    repeat (10) step(1'b0, 1'b0);
    checks++;
    if (n_la != 1 || n_lb + n_lo + n_up != 0)
      $display("FAIL bounce_count load_A=%0d others=%0d want 1/0", n_la, n_lb + n_lo + n_up);
    else passes++;
    checks++;
    if (f_la - start != 7) $display("FAIL bounce_latency got=%0d want=7", f_la - start);
    else passes++;
    checks++;
    if (mm != 0) $display("FAIL bounce_model mismatches=%0d first=%0d want 0", mm, mm_first);
    else passes++;
  endtask

  task automatic test_cancel();
    press(1'b1, 1'b0, 10, 10);
    checks++;
    if (step_leds !== 4'b0100) $display("FAIL cancel_setup got=%b want=0100", step_leds);
    else passes++;
    clear_obs();
    press(1'b0, 1'b1, 10, 10);
    checks++;
    if (n_la + n_lb + n_lo + n_up != 0 || step_leds !== 4'b0001)
      $display("FAIL cancel_op strobes=%0d leds=%b want 0/0001", n_la + n_lb + n_lo + n_up, step_leds);
    else passes++;
    press(1'b1, 1'b0, 10, 10);
    checks++;
    if (n_la != 1 || mm != 0) $display("FAIL cancel_then_enter load_A=%0d mismatches=%0d want 1/0", n_la, mm);
    else passes++;
  endtask

  task automatic test_simultaneous();
    clear_obs();
    press(1'b1, 1'b1, 10, 10);
    checks++;
    if (n_la + n_lb + n_lo + n_up != 0) $display("FAIL simul_strobes got=%0d want=0", n_la + n_lb + n_lo + n_up);
    else passes++;
    checks++;
    if (step_leds !== 4'b0001 || mm != 0) $display("FAIL simul_state leds=%b mismatches=%0d want 0001/0", step_leds, mm);
    else passes++;
  endtask

  task automatic test_held_reset();
    int start;
    btn_enter = 1'b1;
    reset = 1'b0;
    repeat (3) step(1'b1, 1'b0);
    clear_obs();
    start = cyc;
    reset = 1'b1;
    repeat (30) step(1'b1, 1'b0);
    checks++;
    if (n_la != 1 || n_lb + n_lo + n_up != 0)
      $display("FAIL held_count load_A=%0d others=%0d want 1/0", n_la, n_lb + n_lo + n_up);
    else passes++;
    checks++;
    if (f_la - start != DC + 3) $display("FAIL held_latency got=%0d want=%0d", f_la - start, DC + 3);
    else passes++;
    repeat (10) step(1'b0, 1'b0);
    checks++;
    if (mm != 0) $display("FAIL held_model mismatches=%0d first=%0d want 0", mm, mm_first);
    else passes++;
  endtask

  task automatic test_random();
    int done;
    int len;
    logic e, c;
    clear_obs();
    done = 0;
    while (done < 600) begin
      e   = 1'($urandom_range(0, 1));
      c   = ($urandom_range(0, 3) == 0);
      len = $urandom_range(1, 12);
      repeat (len) step(e, c);
      done += len;
    end
    repeat (12) step(1'b0, 1'b0);
    checks++;
    if (mm != 0) $display("FAIL random_model mismatches=%0d first=%0d want 0", mm, mm_first);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_full_sequence();
    test_bounce();
    test_cancel();
    test_simultaneous();
    test_held_reset();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
